mii_rx_byte_assembler: RTL and testbench

- Consumes the registered MII receive signals from the source-synchronous SDR input capture stage (WIDTH=6: rxd[3:0], rx_dv, rx_er) in the recovered RX clock domain.
- Strips preamble and SFD, pairs nibbles into bytes (low nibble first), and tags the last byte of each frame.
- Produces a byte stream with valid, last and bad flags for the downstream MAC receive logic, plus single-cycle status pulses.
- No backpressure: the output rate is fixed by the line.

---
 rtl/mii_rx_pkg.sv | 20 ++
 rtl/mii_rx_byte_hold.sv | 57 +++++
 rtl/mii_rx_byte_assembler.sv | 187 ++++++++++++++++++
 tb/tb_mii_rx_byte_assembler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII receive byte assembler.
package mii_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA_LO  = 3'd2,
        DATA_HI  = 3'd3,
        DROP     = 3'd4
    } rx_state_e;

    localparam logic [3:0] PREAMBLE_NIB      = 4'h5;
    localparam logic [3:0] SFD_NIB           = 4'hD;
    localparam logic [3:0] FALSE_CARRIER_NIB = 4'hE;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'h1;
    endfunction

endpackage

// File: rtl/mii_rx_byte_hold.sv
// One-byte hold register with full flag; emits the held byte with last/bad on request.
module mii_rx_byte_hold
    import mii_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       emit,
    input  logic       emit_last,
    input  logic       emit_bad,
    output logic       full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    output logic       rx_bad
);

    logic [7:0] hold_r;
    logic       full_r;

    assign full = full_r;

    // Capture assembled bytes and present them on the registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r   <= 8'h00;
            full_r   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            if (load) begin
                hold_r <= load_data;
                full_r <= 1'b1;
            end else if (emit) begin
                full_r <= 1'b0;
            end else begin
                full_r <= full_r;
            end

            // rx_data keeps its last value between emissions
            if (emit && full_r) begin
                rx_data  <= hold_r;
                rx_valid <= 1'b1;
                rx_last  <= emit_last;
                rx_bad   <= emit_last & emit_bad;
            end else begin
                rx_valid <= 1'b0;
                rx_last  <= 1'b0;
                rx_bad   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mii_rx_byte_assembler.sv
// MII receive byte assembler: strips preamble/SFD, pairs nibbles low-first into bytes.
// Optional false-carrier detection is enabled by defining MII_RX_FALSE_CARRIER_EN.
module mii_rx_byte_assembler
    import mii_rx_pkg::*;
#(
    parameter int MIN_PREAMBLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    output logic       rx_bad,
    output logic       stat_frame_good,
    output logic       stat_frame_bad,
    output logic       stat_preamble_err,
`ifdef MII_RX_FALSE_CARRIER_EN
    output logic       stat_align_err,
    output logic       stat_false_carrier
`else
    output logic       stat_align_err
`endif
);

    localparam logic [3:0] MIN_PRE_C = MIN_PREAMBLE[3:0];

    rx_state_e  state_r;
    logic [3:0] count_r;
    logic [3:0] low_r;
    logic       bad_r;

    logic       load_s;
    logic [7:0] load_data_s;
    logic       emit_s;
    logic       emit_last_s;
    logic       emit_bad_s;
    logic       full_s;

    // Hold-register control derived from the current state and sampled inputs.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = {mii_rxd, low_r};
        emit_s      = 1'b0;
        emit_last_s = 1'b0;
        emit_bad_s  = 1'b0;
        case (state_r)
            DATA_LO: begin
                if (mii_rx_dv) begin
                    emit_s = full_s;
                end else begin
                    emit_s      = full_s;
                    emit_last_s = 1'b1;
                    emit_bad_s  = bad_r;
                end
            end
            DATA_HI: begin
                if (mii_rx_dv) begin
                    load_s = 1'b1;
                end else begin
                    // odd nibble count: whatever is still held closes the frame as bad
                    emit_s      = full_s;
                    emit_last_s = 1'b1;
                    emit_bad_s  = 1'b1;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    mii_rx_byte_hold u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (load_data_s),
        .emit      (emit_s),
        .emit_last (emit_last_s),
        .emit_bad  (emit_bad_s),
        .full      (full_s),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_last   (rx_last),
        .rx_bad    (rx_bad)
    );

    // Frame state machine with registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            count_r           <= 4'h0;
            low_r             <= 4'h0;
            bad_r             <= 1'b0;
            stat_frame_good   <= 1'b0;
            stat_frame_bad    <= 1'b0;
            stat_preamble_err <= 1'b0;
            stat_align_err    <= 1'b0;
        end else begin
            stat_frame_good   <= 1'b0;
            stat_frame_bad    <= 1'b0;
            stat_preamble_err <= 1'b0;
            stat_align_err    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mii_rx_dv && (mii_rxd == PREAMBLE_NIB)) begin
                        state_r <= PREAMBLE;
                        count_r <= 4'h1;
                    end else if (mii_rx_dv) begin
                        state_r <= DROP;
                    end else begin
                        count_r <= 4'h0;
                    end
                end
                PREAMBLE: begin
                    if (!mii_rx_dv) begin
                        state_r           <= IDLE;
                        stat_preamble_err <= 1'b1;
                    end else if (!mii_rx_er && (mii_rxd == PREAMBLE_NIB)) begin
                        count_r <= sat_inc4(count_r);
                    end else if (!mii_rx_er && (mii_rxd == SFD_NIB) && (count_r >= MIN_PRE_C)) begin
                        state_r <= DATA_LO;
                        bad_r   <= 1'b0;
                    end else begin
                        state_r           <= DROP;
                        stat_preamble_err <= 1'b1;
                    end
                end
                DATA_LO: begin
                    if (mii_rx_dv) begin
                        low_r   <= mii_rxd;
                        bad_r   <= bad_r | mii_rx_er;
                        state_r <= DATA_HI;
                    end else begin
                        // zero-byte frame counts as bad
                        stat_frame_good <= full_s & ~bad_r;
                        stat_frame_bad  <= ~full_s | bad_r;
                        state_r         <= IDLE;
                    end
                end
                DATA_HI: begin
                    if (mii_rx_dv) begin
                        bad_r   <= bad_r | mii_rx_er;
                        state_r <= DATA_LO;
                    end else begin
                        stat_align_err <= 1'b1;
                        stat_frame_bad <= 1'b1;
                        state_r        <= IDLE;
                    end
                end
                DROP: begin
                    if (!mii_rx_dv) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef MII_RX_FALSE_CARRIER_EN
    logic fc_seen_r;

    // False-carrier pulse on the first cycle of the condition; re-armed once er drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_seen_r          <= 1'b0;
            stat_false_carrier <= 1'b0;
        end else begin
            if ((state_r == IDLE) && !mii_rx_dv && mii_rx_er && (mii_rxd == FALSE_CARRIER_NIB)) begin
                stat_false_carrier <= ~fc_seen_r;
                fc_seen_r          <= 1'b1;
            end else begin
                stat_false_carrier <= 1'b0;
                fc_seen_r          <= fc_seen_r & mii_rx_er;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mii_rx_byte_assembler.sv
// Scoreboard bench for mii_rx_byte_assembler: directed frames, queued expectations, decoupled monitor.
module tb_mii_rx_byte_assembler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mii_rxd;
    logic       mii_rx_dv;
    logic       mii_rx_er;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_last;
    logic       rx_bad;
    logic       stat_frame_good;
    logic       stat_frame_bad;
    logic       stat_preamble_err;
    logic       stat_align_err;
    logic       fc_s;

    mii_rx_byte_assembler #(.MIN_PREAMBLE(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mii_rxd           (mii_rxd),
        .mii_rx_dv         (mii_rx_dv),
        .mii_rx_er         (mii_rx_er),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_last           (rx_last),
        .rx_bad            (rx_bad),
        .stat_frame_good   (stat_frame_good),
        .stat_frame_bad    (stat_frame_bad),
        .stat_preamble_err (stat_preamble_err),
`ifdef MII_RX_FALSE_CARRIER_EN
        .stat_align_err    (stat_align_err),
        .stat_false_carrier(fc_s)
`else
        .stat_align_err    (stat_align_err)
`endif
    );

`ifndef MII_RX_FALSE_CARRIER_EN
    assign fc_s = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       bad;
        int         cyc;
    } byte_exp_t;

    typedef struct {
        logic [4:0] stat;
        int         cyc;
    } stat_exp_t;

    // stat vector bits: {false_carrier, good, bad, preamble_err, align_err}
    localparam logic [4:0] S_FC    = 5'b10000;
    localparam logic [4:0] S_GOOD  = 5'b01000;
    localparam logic [4:0] S_BAD   = 5'b00100;
    localparam logic [4:0] S_PRE   = 5'b00010;
    localparam logic [4:0] S_ALIGN = 5'b00001;

    byte_exp_t byte_q[$];
    stat_exp_t stat_q[$];
    int        drv_cyc = 0;
    int        errors = 0;
    int        checks = 0;
    logic      done = 1'b0;
    logic      final_done = 1'b0;

    task automatic drive(input logic v, input logic e, input logic [3:0] d);
        @(negedge clk);
        mii_rx_dv = v;
        mii_rx_er = e;
        mii_rxd   = d;
        drv_cyc   = cyc;
    endtask

    // called right after driving a byte's high nibble; it appears two edges later
    task automatic exp_byte(input logic [7:0] d, input logic l, input logic b);
        byte_q.push_back('{data: d, last: l, bad: b, cyc: drv_cyc + 2});
    endtask

    // called right after driving the nibble whose sampling raises the pulse
    task automatic exp_stat(input logic [4:0] s);
        stat_q.push_back('{stat: s, cyc: drv_cyc + 1});
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
    endtask

    // Monitor: compares every DUT output cycle against the scoreboard queues.
    logic [7:0] held = 8'h00;
    logic       valid_prev = 1'b0;
    always @(posedge clk) begin
        logic [4:0] st;
        byte_exp_t  be;
        stat_exp_t  se;
        #2;
        st = {fc_s, stat_frame_good, stat_frame_bad, stat_preamble_err, stat_align_err};
        if (!rst_n) begin
            checks++;
            if ({rx_data, rx_valid, rx_last, rx_bad, st} != 16'h0000) begin
                errors++;
                $display("FAIL reset_outputs: got data=%h v=%b l=%b b=%b stat=%b, need all zero",
                         rx_data, rx_valid, rx_last, rx_bad, st);
            end
            held = 8'h00;
            valid_prev = 1'b0;
        end else begin
            if (rx_valid) begin
                checks++;
                if (valid_prev) begin
                    errors++;
                    $display("FAIL valid_spacing: got rx_valid on consecutive cycles at cyc %0d, need a gap", cyc);
                end
                checks++;
                if (byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got data=%h last=%b bad=%b at cyc %0d, need no output",
                             rx_data, rx_last, rx_bad, cyc);
                end else begin
                    be = byte_q.pop_front();
                    if (rx_data !== be.data || rx_last !== be.last || rx_bad !== be.bad || cyc != be.cyc) begin
                        errors++;
                        $display("FAIL byte: got data=%h last=%b bad=%b cyc=%0d, need data=%h last=%b bad=%b cyc=%0d",
                                 rx_data, rx_last, rx_bad, cyc, be.data, be.last, be.bad, be.cyc);
                    end
                end
            end else begin
                checks++;
                if (rx_data !== held || rx_last !== 1'b0 || rx_bad !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_hold: got data=%h last=%b bad=%b, need data=%h last=0 bad=0",
                             rx_data, rx_last, rx_bad, held);
                end
            end
            if (st != 5'b00000) begin
                checks++;
                if (stat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_stat: got stat=%b at cyc %0d, need none", st, cyc);
                end else begin
                    se = stat_q.pop_front();
                    if (st !== se.stat || cyc != se.cyc) begin
                        errors++;
                        $display("FAIL stat: got stat=%b cyc=%0d, need stat=%b cyc=%0d",
                                 st, cyc, se.stat, se.cyc);
                    end
                end
            end
            held = rx_data;
            valid_prev = rx_valid;
        end
        if (done && !final_done) begin
            checks++;
            if (byte_q.size() != 0 || stat_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d bytes and %0d stats still pending, need 0 and 0",
                         byte_q.size(), stat_q.size());
            end
            final_done = 1'b1;
        end
    end

    initial begin
        rst_n     = 1'b0;
        mii_rx_dv = 1'b0;
        mii_rx_er = 1'b0;
        mii_rxd   = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'h0);

        // clean frame after a long preamble
        preamble(15);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h2); exp_byte(8'h21, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'h3);
        drive(1'b1, 1'b0, 4'h4); exp_byte(8'h43, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'h0); exp_stat(S_GOOD);

        // back-to-back after a one-cycle gap; er on nibble 3
        preamble(15);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h2); exp_byte(8'h21, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h3);
        drive(1'b1, 1'b0, 4'h4); exp_byte(8'h43, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'h0); exp_stat(S_BAD);
        drive(1'b0, 1'b0, 4'h0);

        // SFD after one preamble nibble is too short
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD); exp_stat(S_PRE);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h2);
        drive(1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'h0);

        // odd nibble count: byte A5, orphan 7
        preamble(2);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hA); exp_byte(8'hA5, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'h7);
        drive(1'b0, 1'b0, 4'h0); exp_stat(S_ALIGN | S_BAD);
        drive(1'b0, 1'b0, 4'h0);

        // zero-byte frame
        preamble(2);
        drive(1'b0, 1'b0, 4'h0); exp_stat(S_BAD);
        drive(1'b0, 1'b0, 4'h0);

        // reset mid-data, released while dv=1 with rxd=3
        preamble(2);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h2);
        @(negedge clk);
        rst_n = 1'b0; mii_rx_dv = 1'b1; mii_rx_er = 1'b0; mii_rxd = 4'h3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'h3);
        drive(1'b1, 1'b0, 4'h3);
        drive(1'b0, 1'b0, 4'h0);
        preamble(2);
        drive(1'b1, 1'b0, 4'h8);
        drive(1'b1, 1'b0, 4'h9); exp_byte(8'h98, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'h0); exp_stat(S_GOOD);
        drive(1'b0, 1'b0, 4'h0);

        // false-carrier pattern between frames
        drive(1'b0, 1'b1, 4'hE);
`ifdef MII_RX_FALSE_CARRIER_EN
        exp_stat(S_FC);
`endif
        drive(1'b0, 1'b1, 4'hE);
        drive(1'b0, 1'b1, 4'hE);
        drive(1'b0, 1'b1, 4'hE);
        drive(1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 4'hE);
`ifdef MII_RX_FALSE_CARRIER_EN
        exp_stat(S_FC);
`endif
        drive(1'b0, 1'b0, 4'h0);

        repeat (4) drive(1'b0, 1'b0, 4'h0);
        done = 1'b1;
        repeat (2) @(posedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
